// File: rtl/core_reset_sequencer_if.sv
// APF bridge read port used by the core reset sequencer.
// The master drives address and read strobe; the slave returns read data.
`timescale 1ns/1ps

interface core_reset_sequencer_if;
    logic [31:0] bridge_addr;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;

    modport master (
        output bridge_addr,
        output bridge_rd,
        input  bridge_rd_data
    );

    modport slave (
        input  bridge_addr,
        input  bridge_rd,
        output bridge_rd_data
    );
endinterface

// File: rtl/core_reset_sequencer.sv
// Core reset sequencer (clk_74a domain).
// Merges reset requests into one stretched, active-low core reset:
// hold for HOLD_CYCLES, wait for PLL lock, then a guard window before
// another reset may start. A status word is readable over the APF bridge.
`timescale 1ns/1ps

module core_reset_sequencer #(
    parameter int          NUM_SRC      = 4,
    parameter int          HOLD_CYCLES  = 8000,
    parameter int          GUARD_CYCLES = 256,
    parameter logic [31:0] STATUS_ADDR  = 32'hF000_0020
) (
    input  logic                   clk_74a,
    input  logic                   reset_n,
    input  logic [NUM_SRC-1:0]     rst_req,
    input  logic                   pll_locked,
    output logic                   core_reset_n,
    output logic                   seq_busy,
    output logic [NUM_SRC-1:0]     last_cause,
    output logic [15:0]            reset_count,
    core_reset_sequencer_if.slave  bridge
);

    localparam int CNT_MAX = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        WAIT_LOCK = 2'd2,
        GUARD     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SRC-1:0]   last_cause_q, last_cause_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [15:0]          reset_count_q, reset_count_d;
    logic                 core_reset_n_q, core_reset_n_d;
    logic                 seq_busy_q, seq_busy_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 count_inc_s;
    logic                 req_any_s;
    logic [NUM_SRC-1:0]   pend_all_s;
    logic [11:0]          cause_ext_s;

    assign req_any_s  = |rst_req;
    assign pend_all_s = pending_q | rst_req;

    // Sequencer next-state, counter, cause and pending-request logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_cause_d = last_cause_q;
        pending_d    = pending_q;
        count_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any_s) begin
                    state_d      = HOLD;
                    cnt_d        = HOLD_LOAD;
                    last_cause_d = rst_req;
                    count_inc_s  = 1'b1;
                end else if (!pll_locked) begin
                    state_d      = HOLD;
                    cnt_d        = HOLD_LOAD;
                    last_cause_d = '0;
                    count_inc_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (req_any_s) begin
                    // A request always wins, even on the last hold cycle.
                    cnt_d        = HOLD_LOAD;
                    last_cause_d = last_cause_q | rst_req;
                end else if (cnt_q == '0) begin
                    // With lock already present release directly, so the low
                    // time is exactly HOLD_CYCLES; otherwise park in WAIT_LOCK.
                    if (pll_locked) begin
                        state_d = GUARD;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (req_any_s) begin
                    state_d      = HOLD;
                    cnt_d        = HOLD_LOAD;
                    last_cause_d = last_cause_q | rst_req;
                end else if (pll_locked) begin
                    state_d = GUARD;
                    cnt_d   = GUARD_LOAD;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            GUARD: begin
                if (!pll_locked) begin
                    state_d      = HOLD;
                    cnt_d        = HOLD_LOAD;
                    last_cause_d = pend_all_s;
                    pending_d    = '0;
                    count_inc_s  = 1'b1;
                end else if (cnt_q == '0) begin
                    pending_d = '0;
                    if (pend_all_s != '0) begin
                        state_d      = HOLD;
                        cnt_d        = HOLD_LOAD;
                        last_cause_d = pend_all_s;
                        count_inc_s  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    pending_d = pend_all_s;
                end
            end
            default: begin
                // Unreachable encoding: fall back into a fresh hold.
                state_d   = HOLD;
                cnt_d     = HOLD_LOAD;
                pending_d = '0;
            end
        endcase
    end

    // Registered outputs derived from the next state, saturating reset counter.
    always_comb begin
        core_reset_n_d = (state_d == IDLE) || (state_d == GUARD);
        seq_busy_d     = (state_d != IDLE);
        if (count_inc_s && (reset_count_q != 16'hFFFF)) begin
            reset_count_d = reset_count_q + 16'd1;
        end else begin
            reset_count_d = reset_count_q;
        end
    end

    // Status word assembly and bridge read-data capture.
    always_comb begin
        cause_ext_s              = 12'd0;
        cause_ext_s[NUM_SRC-1:0] = last_cause_q;
        if (bridge.bridge_rd && (bridge.bridge_addr == STATUS_ADDR)) begin
            rd_data_d = {core_reset_n_q, seq_busy_q, state_q, cause_ext_s, reset_count_q};
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State and datapath registers; reset starts a full hold.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HOLD;
            cnt_q          <= HOLD_LOAD;
            last_cause_q   <= '0;
            pending_q      <= '0;
            reset_count_q  <= 16'd0;
            core_reset_n_q <= 1'b0;
            seq_busy_q     <= 1'b1;
            rd_data_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_cause_q   <= last_cause_d;
            pending_q      <= pending_d;
            reset_count_q  <= reset_count_d;
            core_reset_n_q <= core_reset_n_d;
            seq_busy_q     <= seq_busy_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign core_reset_n          = core_reset_n_q;
    assign seq_busy              = seq_busy_q;
    assign last_cause            = last_cause_q;
    assign reset_count           = reset_count_q;
    assign bridge.bridge_rd_data = rd_data_q;

endmodule

// File: tb/tb_core_reset_sequencer.sv
// Directed self-checking bench for core_reset_sequencer (default parameters).
`timescale 1ns/1ps

module tb_core_reset_sequencer;

    localparam int LIMIT = 20000;

    logic        clk;
    logic        reset_n;
    logic [3:0]  rst_req;
    logic        pll_locked;
    logic        core_reset_n;
    logic        seq_busy;
    logic [3:0]  last_cause;
    logic [15:0] reset_count;
    int          n_cmp;
    int          n_err;
    int          n;

    core_reset_sequencer_if bif ();

    core_reset_sequencer dut (
        .clk_74a      (clk),
        .reset_n      (reset_n),
        .rst_req      (rst_req),
        .pll_locked   (pll_locked),
        .core_reset_n (core_reset_n),
        .seq_busy     (seq_busy),
        .last_cause   (last_cause),
        .reset_count  (reset_count),
        .bridge       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples (including the current one) with core_reset_n low.
    task automatic count_low(output int cnt);
        cnt = 0;
        while (core_reset_n === 1'b0 && cnt < LIMIT) begin
            cnt++;
            step();
        end
    endtask

    // Samples (including the current one) spent in the released guard window.
    task automatic count_guard(output int cnt);
        cnt = 0;
        while (core_reset_n === 1'b1 && seq_busy === 1'b1 && cnt < LIMIT) begin
            cnt++;
            step();
        end
    endtask

    task automatic bridge_read(input logic [31:0] addr);
        bif.bridge_addr = addr;
        bif.bridge_rd   = 1'b1;
        step();
        bif.bridge_rd   = 1'b0;
        bif.bridge_addr = 32'd0;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        reset_n         = 1'b0;
        rst_req         = 4'b0000;
        pll_locked      = 1'b1;
        bif.bridge_addr = 32'd0;
        bif.bridge_rd   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        chk("rst_seq_busy", {31'd0, seq_busy}, 32'd1);
        chk("rst_count", {16'd0, reset_count}, 32'd0);
        chk("rst_cause", {28'd0, last_cause}, 32'd0);
        chk("rst_rd_data", bif.bridge_rd_data, 32'd0);

        // 1: power-on hold, guard, idle; power-on reset is not counted
        reset_n = 1'b1;
        count_low(n);
        chk("t1_low_len", n, 32'd8000);
        count_guard(n);
        chk("t1_guard_len", n, 32'd256);
        chk("t1_idle", {31'd0, seq_busy}, 32'd0);
        chk("t1_count", {16'd0, reset_count}, 32'd0);

        // 2: single request from IDLE
        rst_req = 4'b0010;
        step();
        rst_req = 4'b0000;
        chk("t2_low_next_edge", {31'd0, core_reset_n}, 32'd0);
        chk("t2_cause", {28'd0, last_cause}, 32'd2);
        chk("t2_count", {16'd0, reset_count}, 32'd1);
        count_low(n);
        chk("t2_low_len", n, 32'd8000);
        count_guard(n);
        chk("t2_guard_len", n, 32'd256);

        // 3: extension while in HOLD at cnt=100
        rst_req = 4'b0010;
        step();
        rst_req = 4'b0000;
        repeat (7899) step();
        rst_req = 4'b0100;
        step();
        rst_req = 4'b0000;
        chk("t3_cause", {28'd0, last_cause}, 32'd6);
        chk("t3_count", {16'd0, reset_count}, 32'd2);
        count_low(n);
        chk("t3_low_len", n, 32'd8000);

        // 4: request during guard is deferred until the window expires
        n = 0;
        while (core_reset_n === 1'b1 && n < LIMIT) begin
            rst_req = (n == 10) ? 4'b0001 : 4'b0000;
            n++;
            step();
        end
        rst_req = 4'b0000;
        chk("t4_high_len", n, 32'd256);
        chk("t4_busy", {31'd0, seq_busy}, 32'd1);
        chk("t4_cause", {28'd0, last_cause}, 32'd1);
        chk("t4_count", {16'd0, reset_count}, 32'd3);
        count_low(n);
        chk("t4_low_len", n, 32'd8000);
        count_guard(n);
        chk("t4_guard_len", n, 32'd256);

        // 6: status read in IDLE after three resets
        bridge_read(32'hF000_0020);
        chk("t6_status_idle", bif.bridge_rd_data, 32'h8001_0003);

        // 5: lock loss in IDLE, then a long WAIT_LOCK
        pll_locked = 1'b0;
        step();
        chk("t5_lockloss_low", {31'd0, core_reset_n}, 32'd0);
        chk("t5_lockloss_cause", {28'd0, last_cause}, 32'd0);
        chk("t5_lockloss_count", {16'd0, reset_count}, 32'd4);
        bridge_read(32'hF000_0000);
        chk("t6_other_addr_hold", bif.bridge_rd_data, 32'h8001_0003);
        repeat (13000) step();
        chk("t5_waitlock_low", {31'd0, core_reset_n}, 32'd0);
        chk("t5_waitlock_busy", {31'd0, seq_busy}, 32'd1);
        bridge_read(32'hF000_0020);
        chk("t5_status_waitlock", bif.bridge_rd_data, 32'h6000_0004);
        pll_locked = 1'b1;
        step();
        chk("t5_release", {31'd0, core_reset_n}, 32'd1);
        count_guard(n);
        chk("t5_guard_len", n, 32'd256);
        chk("t5_idle", {31'd0, seq_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
